cpu_exec_path: RTL and testbench

Parametrised successor to the 16-bit CPU datapath. It sequences one instruction at a time through operand fetch, execute and writeback. It owns the register file, operand muxing and PC update, and drives an external execution unit (ALU/APB master) through a valid/done handshake with an optional watchdog timeout. It sits between the instruction-fetch/control logic (which supplies IR, PC and decoded selects) and the ALU.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/rf_param.sv | 38 +++
 rtl/cpu_exec_path.sv | 146 ++++++++++++++
 tb/tb_cpu_exec_path.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Types and encodings shared by the CPU execution path, its register file
// and the external ALU.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OPERAND,
    EXEC,
    WB
  } state_t;

  // Operand and writeback mux selects
  localparam logic SEL_REG  = 1'b0;
  localparam logic SEL_PC   = 1'b1;
  localparam logic SEL_IR   = 1'b1;
  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_ALU  = 1'b1;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SHL  = 3'd5;
  localparam logic [2:0] ALU_SHR  = 3'd6;
  localparam logic [2:0] ALU_PASS = 3'd7;

endpackage

// File: rtl/rf_param.sv
// Parametrised register file: one synchronous write port, two combinational
// read ports, optional hard-wired zero register.
module rf_param #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ZERO_REG = 1,
  localparam int SEL_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [SEL_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [SEL_W-1:0]  raddr1,
  input  logic [SEL_W-1:0]  raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              zero_hit;

  assign zero_hit = (ZERO_REG != 0) && (waddr == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && !zero_hit) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = ((ZERO_REG != 0) && (raddr1 == '0)) ? '0 : regs[raddr1];
  assign rdata2 = ((ZERO_REG != 0) && (raddr2 == '0)) ? '0 : regs[raddr2];

endmodule

// File: rtl/cpu_exec_path.sv
// Execution path: sequences one instruction through operand fetch, an
// external execute handshake (with optional watchdog) and writeback.
module cpu_exec_path #(
  parameter int              DATA_W   = 16,
  parameter int              NUM_REGS = 8,
  parameter int              ZERO_REG = 1,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 0,
  localparam int             SEL_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic [SEL_W-1:0]  rs1_sel,
  input  logic [SEL_W-1:0]  rs2_sel,
  input  logic              op_a_sel,
  input  logic              op_b_sel,
  input  logic [2:0]        alu_op,
  input  logic              wb_en,
  input  logic              wb_sel,
  input  logic              pc_sel,
  input  logic [DATA_W-1:0] data_in,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [2:0]        ex_op,
  input  logic              ex_done,
  input  logic [DATA_W-1:0] ex_result,
  output logic [DATA_W-1:0] pc_out,
  output logic              next_ir,
  output logic              busy,
  output logic              err,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  import cpu_pkg::*;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            state;
  logic [DATA_W-1:0] ir_q, pc_q, result_q, wr_data, pc_inc;
  logic [SEL_W-1:0]  rd_q, rs1_q, rs2_q, raddr1, raddr2;
  logic              op_a_q, op_b_q, wb_en_q, wb_sel_q, pc_sel_q, rf_we;
  logic [CNT_W-1:0]  cnt;

  assign ex_valid = (state == EXEC);
  assign next_ir  = (state == IDLE);
  assign busy     = (state != IDLE);
  assign pc_inc   = pc_q + DATA_W'(1);

  // Read ports follow the live selects while idle so callers can inspect
  // the register file; during an instruction they use the latched selects.
  assign raddr1  = (state == IDLE) ? rs1_sel : rs1_q;
  assign raddr2  = (state == IDLE) ? rs2_sel : rs2_q;
  assign rf_we   = (state == WB) && wb_en_q;
  assign wr_data = (wb_sel_q == SEL_ALU) ? result_q : data_in;

  rf_param #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ZERO_REG(ZERO_REG)
  ) u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .waddr (rd_q),
    .wdata (wr_data),
    .raddr1(raddr1),
    .raddr2(raddr2),
    .rdata1(rs1_data),
    .rdata2(rs2_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ir_q     <= '0;
      pc_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      op_a_q   <= 1'b0;
      op_b_q   <= 1'b0;
      wb_en_q  <= 1'b0;
      wb_sel_q <= 1'b0;
      pc_sel_q <= 1'b0;
      result_q <= '0;
      cnt      <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_op    <= '0;
      err      <= 1'b0;
      pc_out   <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ir_q     <= ir;
            pc_q     <= pc_in;
            rd_q     <= rd_sel;
            rs1_q    <= rs1_sel;
            rs2_q    <= rs2_sel;
            op_a_q   <= op_a_sel;
            op_b_q   <= op_b_sel;
            ex_op    <= alu_op;
            wb_en_q  <= wb_en;
            wb_sel_q <= wb_sel;
            pc_sel_q <= pc_sel;
            err      <= 1'b0;
            state    <= OPERAND;
          end
        end
        OPERAND: begin
          ex_a  <= (op_a_q == SEL_PC) ? pc_q : rs1_data;
          ex_b  <= (op_b_q == SEL_IR) ? ir_q : rs2_data;
          cnt   <= '0;
          state <= EXEC;
        end
        // ex_done takes priority over a watchdog expiry in the same cycle
        EXEC: begin
          if (ex_done) begin
            result_q <= ex_result;
            state    <= WB;
          end else if (TIMEOUT != 0 && cnt == TERM) begin
            err    <= 1'b1;
            pc_out <= pc_inc;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB: begin
          pc_out <= (pc_sel_q == SEL_ALU) ? result_q : pc_inc;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_exec_path.sv
// Self-checking bench for cpu_exec_path: table-driven directed vectors,
// randomized instructions against a behavioural model, and reset corner cases.
module tb_cpu_exec_path;

  localparam int          DATA_W   = 16;
  localparam int          NUM_REGS = 8;
  localparam int          SEL_W    = 3;
  localparam int          TIMEOUT  = 4;
  localparam logic [15:0] RESET_PC = 16'h0100;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] ir = '0, pc_in = '0, data_in = '0, ex_result = '0;
  logic [SEL_W-1:0]  rd_sel = '0, rs1_sel = '0, rs2_sel = '0;
  logic              op_a_sel = 1'b0, op_b_sel = 1'b0;
  logic [2:0]        alu_op = '0;
  logic              wb_en = 1'b0, wb_sel = 1'b0, pc_sel = 1'b0, ex_done = 1'b0;
  logic              ex_valid, next_ir, busy, err;
  logic [DATA_W-1:0] ex_a, ex_b, pc_out, rs1_data, rs2_data;
  logic [2:0]        ex_op;

  cpu_exec_path #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ZERO_REG(1),
    .RESET_PC(RESET_PC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ir       (ir),
    .pc_in    (pc_in),
    .rd_sel   (rd_sel),
    .rs1_sel  (rs1_sel),
    .rs2_sel  (rs2_sel),
    .op_a_sel (op_a_sel),
    .op_b_sel (op_b_sel),
    .alu_op   (alu_op),
    .wb_en    (wb_en),
    .wb_sel   (wb_sel),
    .pc_sel   (pc_sel),
    .data_in  (data_in),
    .ex_valid (ex_valid),
    .ex_a     (ex_a),
    .ex_b     (ex_b),
    .ex_op    (ex_op),
    .ex_done  (ex_done),
    .ex_result(ex_result),
    .pc_out   (pc_out),
    .next_ir  (next_ir),
    .busy     (busy),
    .err      (err),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  always #5 clk = ~clk;

  // done_at: EXEC cycle index in which ex_done is raised; -1 means never
  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc_in;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        a_sel;
    logic        b_sel;
    logic [2:0]  op;
    logic        wb_en;
    logic        wb_sel;
    logic        pc_sel;
    int          done_at;
    logic [15:0] result;
    logic [15:0] data;
    logic        inject;
    logic [15:0] exp_pc;
    logic        exp_err;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_rf [NUM_REGS];
  vec_t        vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkRegs();
    for (int r = 0; r < NUM_REGS; r++) begin
      rs1_sel = 3'(r);
      rs2_sel = 3'(NUM_REGS - 1 - r);
      #1;
      checkOutput("rf_rs1", 32'(rs1_data), 32'(model_rf[r]));
      checkOutput("rf_rs2", 32'(rs2_data), 32'(model_rf[NUM_REGS-1-r]));
    end
  endtask

  task automatic checkIdleReset();
    checkOutput("rst_next_ir", 32'(next_ir), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_pc_out", 32'(pc_out), 32'(RESET_PC));
    checkOutput("rst_ex_a", 32'(ex_a), 32'd0);
    checkOutput("rst_ex_b", 32'(ex_b), 32'd0);
    checkOutput("rst_ex_op", 32'(ex_op), 32'd0);
    for (int r = 0; r < NUM_REGS; r++) model_rf[r] = '0;
    checkRegs();
  endtask

  task automatic scrambleInputs();
    ir       = 16'($urandom);
    pc_in    = 16'($urandom);
    rd_sel   = 3'($urandom);
    rs1_sel  = 3'($urandom);
    rs2_sel  = 3'($urandom);
    op_a_sel = 1'($urandom);
    op_b_sel = 1'($urandom);
    alu_op   = 3'($urandom);
    wb_en    = 1'($urandom);
    wb_sel   = 1'($urandom);
    pc_sel   = 1'($urandom);
    data_in  = 16'($urandom);
  endtask

  // Runs one instruction from IDLE back to IDLE and checks it end to end
  task automatic applyStimulus(input vec_t v);
    logic [15:0] exp_a, exp_b;
    int          cycles, exp_cycles;
    bit          done_seen;
    exp_a = v.a_sel ? v.pc_in : model_rf[v.rs1];
    exp_b = v.b_sel ? v.ir : model_rf[v.rs2];
    start = 1'b1; ir = v.ir; pc_in = v.pc_in; rd_sel = v.rd;
    rs1_sel = v.rs1; rs2_sel = v.rs2; op_a_sel = v.a_sel; op_b_sel = v.b_sel;
    alu_op = v.op; wb_en = v.wb_en; wb_sel = v.wb_sel; pc_sel = v.pc_sel;
    @(posedge clk); #1;
    start = 1'b0;
    scrambleInputs();
    ex_done = 1'b1;
    ex_result = 16'($urandom);
    checkOutput("operand_busy", 32'(busy), 32'd1);
    checkOutput("operand_next_ir", 32'(next_ir), 32'd0);
    checkOutput("operand_err_clear", 32'(err), 32'd0);
    checkOutput("operand_ex_valid", 32'(ex_valid), 32'd0);
    @(posedge clk); #1;
    ex_done = 1'b0;
    checkOutput("ex_a", 32'(ex_a), 32'(exp_a));
    checkOutput("ex_b", 32'(ex_b), 32'(exp_b));
    checkOutput("ex_op", 32'(ex_op), 32'(v.op));
    cycles = 0;
    done_seen = 0;
    while (ex_valid && cycles < 20) begin
      start = v.inject && (cycles == 0);
      if (cycles == v.done_at) begin
        ex_done = 1'b1;
        ex_result = v.result;
        done_seen = 1;
      end
      @(posedge clk); #1;
      ex_done = 1'b0;
      ex_result = 16'($urandom);
      start = 1'b0;
      cycles++;
      if (ex_valid) checkOutput("ex_a_stable", 32'(ex_a), 32'(exp_a));
    end
    exp_cycles = (v.done_at >= 0 && v.done_at < TIMEOUT) ? v.done_at + 1 : TIMEOUT;
    checkOutput("exec_cycles", 32'(cycles), 32'(exp_cycles));
    if (done_seen) begin
      data_in = v.data;
      @(posedge clk); #1;
      data_in = 16'($urandom);
      if (v.wb_en && v.rd != 0) model_rf[v.rd] = v.wb_sel ? v.result : v.data;
    end
    checkOutput("done_next_ir", 32'(next_ir), 32'd1);
    checkOutput("done_busy", 32'(busy), 32'd0);
    checkOutput("done_pc_out", 32'(pc_out), 32'(v.exp_pc));
    checkOutput("done_err", 32'(err), 32'(v.exp_err));
    checkRegs();
    @(posedge clk); #1;
    checkOutput("idle_hold", 32'(next_ir), 32'd1);
  endtask

  function automatic vec_t mk(input logic [15:0] ir_v, input logic [15:0] pc_v,
                               input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                               input logic a_s, input logic b_s, input logic [2:0] op,
                               input logic we, input logic ws, input logic ps, input int done_at,
                               input logic [15:0] res, input logic [15:0] dat, input logic inj,
                               input logic [15:0] epc, input logic eerr);
    vec_t v;
    v.ir = ir_v; v.pc_in = pc_v; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.a_sel = a_s; v.b_sel = b_s; v.op = op; v.wb_en = we; v.wb_sel = ws;
    v.pc_sel = ps; v.done_at = done_at; v.result = res; v.data = dat;
    v.inject = inj; v.exp_pc = epc; v.exp_err = eerr;
    return v;
  endfunction

  initial begin
    vec_t        rv, hv;
    logic [15:0] inc;
    for (int r = 0; r < NUM_REGS; r++) model_rf[r] = '0;

    //            ir       pc_in    rd rs1 rs2 a b op  we ws ps done res      data     inj exp_pc   err
    vecs[0] = mk(16'h1111, 16'h0010, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'hDEAD, 16'h0005, 0, 16'h0011, 0);
    vecs[1] = mk(16'h2222, 16'h0011, 2, 0, 0, 0, 0, 0, 1, 0, 0, 1, 16'hBEEF, 16'h0003, 0, 16'h0012, 0);
    vecs[2] = mk(16'h3333, 16'h0012, 3, 1, 2, 0, 0, 0, 1, 1, 0, 0, 16'h0008, 16'h9999, 0, 16'h0013, 0);
    vecs[3] = mk(16'h4444, 16'h0013, 5, 3, 1, 1, 1, 7, 0, 1, 1, 0, 16'h0040, 16'h7777, 0, 16'h0040, 0);
    vecs[4] = mk(16'h5555, 16'hFFFF, 6, 1, 3, 0, 1, 2, 0, 0, 0, 2, 16'h1234, 16'h4321, 0, 16'h0000, 0);
    vecs[5] = mk(16'h6666, 16'h0200, 4, 2, 3, 0, 0, 1, 1, 1, 1, -1, 16'h0000, 16'hAAAA, 0, 16'h0201, 1);
    vecs[6] = mk(16'h7777, 16'h0300, 4, 3, 2, 1, 0, 3, 1, 0, 0, 2, 16'h5A5A, 16'h0077, 0, 16'h0301, 0);
    vecs[7] = mk(16'h8888, 16'h0400, 0, 0, 4, 0, 0, 4, 1, 0, 0, 0, 16'h0000, 16'h1234, 0, 16'h0401, 0);
    vecs[8] = mk(16'h9999, 16'h0500, 5, 4, 0, 0, 0, 5, 1, 1, 1, 3, 16'h0055, 16'h0000, 0, 16'h0055, 0);
    vecs[9] = mk(16'hAAAA, 16'h0600, 6, 5, 3, 0, 1, 6, 1, 0, 0, 1, 16'h0000, 16'h00C3, 1, 16'h0601, 0);

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    checkIdleReset();

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    for (int i = 0; i < 25; i++) begin
      rv = mk(16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
              1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 0, 16'($urandom), 16'($urandom), 1'($urandom), 16'h0, 0);
      rv.done_at = $urandom_range(0, 5);
      if (rv.done_at >= TIMEOUT) rv.done_at = -1;
      inc = rv.pc_in + 16'd1;
      rv.exp_err = (rv.done_at < 0);
      rv.exp_pc  = (rv.done_at >= 0 && rv.pc_sel) ? rv.result : inc;
      applyStimulus(rv);
    end

    // Leave err set, then reset in the middle of EXEC
    applyStimulus(mk(16'h0BAD, 16'h0700, 2, 1, 1, 0, 0, 0, 1, 0, 0, -1, 16'h0, 16'h0, 0, 16'h0701, 1));
    start = 1'b1; ir = 16'hCAFE; pc_in = 16'h0800; rd_sel = 3'd3; rs1_sel = 3'd1;
    rs2_sel = 3'd2; op_a_sel = 1'b0; op_b_sel = 1'b1; alu_op = 3'd1; wb_en = 1'b1;
    wb_sel = 1'b0; pc_sel = 1'b0; data_in = 16'h3C3C;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("pre_reset_ex_valid", 32'(ex_valid), 32'd1);
    reset = 1'b0;
    ex_done = 1'b1;
    ex_result = 16'h0F0F;
    @(posedge clk); #1;
    reset = 1'b1;
    ex_done = 1'b0;
    checkIdleReset();

    hv = mk(16'h0001, 16'h0900, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 16'h0000, 16'h00AA, 0, 16'h0901, 0);
    applyStimulus(hv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
